// File: rtl/alu.sv
// alu: single-cycle registered multiply/divide unit with a 1-cycle result latency.
// Define ALU_MULH_EN to include the MULH/MULHSU/MULHU high-product operations.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] result
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  logic [3:0] op;
  logic unused_bits;
  logic div0, ovf, hi_sel;
  logic [WIDTH-1:0] mul_lo, b_safe, divu_q, remu_r, a_abs, b_abs, div_q, rem_r, hi;
  logic [WIDTH-1:0] result_d, result_q;
`ifdef ALU_MULH_EN
  logic [2*WIDTH-1:0] a_sx, a_zx, b_sx, b_zx, p_ss, p_su, p_uu;
  always_comb begin
    a_sx = {{WIDTH{rs1[WIDTH-1]}}, rs1};
    a_zx = {{WIDTH{1'b0}}, rs1};
    b_sx = {{WIDTH{rs2[WIDTH-1]}}, rs2};
    b_zx = {{WIDTH{1'b0}}, rs2};
    // 2*WIDTH-bit wraparound products of extended operands equal the exact signed/unsigned products
    p_ss = a_sx * b_sx;
    p_su = a_sx * b_zx;
    p_uu = a_zx * b_zx;
    hi_sel = op == 4'b0010 || op == 4'b0011 || op == 4'b1001;
    hi = op == 4'b0010 ? p_ss[2*WIDTH-1:WIDTH] :
         op == 4'b0011 ? p_su[2*WIDTH-1:WIDTH] :
         op == 4'b1001 ? p_uu[2*WIDTH-1:WIDTH] : '0;
  end
`else
  assign hi_sel = 1'b0;
  assign hi = '0;
`endif
  always_comb begin
    op = instruction[3:0];
    unused_bits = ^instruction[31:4];
    mul_lo = rs1 * rs2;
    div0 = rs2 == '0;
    ovf = rs1 == MIN_NEG && rs2 == '1;
    // a dummy divisor of 1 keeps the dividers defined; the zero case is muxed out below
    b_safe = div0 ? ONE : rs2;
    divu_q = rs1 / b_safe;
    remu_r = rs1 % b_safe;
    a_abs = rs1[WIDTH-1] ? -rs1 : rs1;
    b_abs = b_safe[WIDTH-1] ? -b_safe : b_safe;
    div_q = (rs1[WIDTH-1] ^ rs2[WIDTH-1]) ? -(a_abs / b_abs) : a_abs / b_abs;
    rem_r = rs1[WIDTH-1] ? -(a_abs % b_abs) : a_abs % b_abs;
    result_d = !reset        ? '0 :
               hi_sel        ? hi :
               op == 4'b0001 ? mul_lo :
               op == 4'b0100 ? (div0 ? '1 : ovf ? rs1 : div_q) :
               op == 4'b0101 ? (div0 ? '1 : divu_q) :
               op == 4'b0110 ? (div0 ? rs1 : ovf ? '0 : rem_r) :
               op == 4'b0111 ? (div0 ? rs1 : remu_r) : '0;
  end
  always_ff @(posedge clk) result_q <= result_d;
  assign result = result_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard-driven bench for alu; expectations for the high-product ops follow ALU_MULH_EN.
module tb_alu;
  logic clk = 0;
  logic reset = 0;
  logic [31:0] instruction = 0, rs1 = 0, rs2 = 0;
  logic [31:0] result;
  logic [31:0] exp_q[$];
  int errors = 0, checks = 0;

  alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .instruction(instruction), .rs1(rs1), .rs2(rs2), .result(result));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      4'b0001: begin pu = ua * ub; return pu[31:0]; end
      4'b0100: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      4'b0101: begin
        if (b == 0) return 32'hFFFFFFFF;
        pu = ua / ub; return pu[31:0];
      end
      4'b0110: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      4'b0111: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
`ifdef ALU_MULH_EN
      4'b0010: begin p = sa * sb; return p[63:32]; end
      4'b0011: begin p = sa * longint'(ub); return p[63:32]; end
      4'b1001: begin pu = ua * ub; return pu[63:32]; end
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    instruction = ins; rs1 = a; rs2 = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      drive(32'h1, 32'd6 + i, 32'd7, 32'h0);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e) begin errors++; $display("FAIL reset_hold%0d got=%h exp=%h", i, result, e); end
    end
    reset = 1;
    drive(32'h1, 32'd6, 32'd7, 32'd42);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (result !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", result, e); end
  endtask

  task automatic test_ops(input string name, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e_spec);
    logic [31:0] e;
    drive(ins, a, b, e_spec);
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (result !== e) begin errors++; $display("FAIL %s got=%h exp=%h", name, result, e); end
  endtask

  task automatic test_mulh();
`ifdef ALU_MULH_EN
    test_ops("mulhu", 32'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    test_ops("mulh", 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    test_ops("mulhsu", 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    test_ops("mulhu_off", 32'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    test_ops("mulh_off", 32'h2, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    test_ops("mulhsu_off", 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
`endif
  endtask

  task automatic test_back_to_back(input bit mid_reset);
    logic [31:0] e;
    logic [31:0] ins[3] = '{32'h1, 32'h4, 32'h0};
    logic [31:0] a[3] = '{32'd6, 32'd10, 32'd99};
    logic [31:0] b[3] = '{32'd7, 32'd2, 32'd3};
    logic [31:0] r[3] = '{32'd42, 32'd5, 32'd0};
    for (int i = 0; i < 3; i++) begin
      reset = !(mid_reset && i == 1);
      drive(ins[i], a[i], b[i], (mid_reset && i == 1) ? 32'h0 : r[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e) begin errors++; $display("FAIL b2b%0d_rst%0d got=%h exp=%h", i, mid_reset, result, e); end
    end
    reset = 1;
  endtask

  task automatic test_random();
    logic [31:0] e, a, b, ins;
    logic [3:0] ops[10] = '{4'h1, 4'h2, 4'h3, 4'h9, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'hF};
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = (i % 7 == 3) ? 32'h0 : $urandom;
      if (i % 5 == 1) b = b & 32'hFF;
      ins = {$urandom_range(0, 32'h0FFFFFFF), ops[i % 10]};
      drive(ins, a, b, model(ins[3:0], a, b));
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (result !== e) begin errors++; $display("FAIL rand%0d op=%h a=%h b=%h got=%h exp=%h", i, ins[3:0], a, b, result, e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ops("mul_upper_bits", 32'hFFFFFFF1, 32'd1000, 32'd3000, 32'd3000000);
    test_ops("div", 32'h4, 32'd10, 32'd2, 32'd5);
    test_ops("divu", 32'h5, 32'd10, 32'd2, 32'd5);
    test_ops("rem", 32'h6, 32'd10, 32'd3, 32'd1);
    test_ops("div_neg", 32'h4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    test_ops("rem_neg", 32'h6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    test_ops("divu_big", 32'h5, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF);
    test_ops("div_zero", 32'h4, 32'd1234, 32'd0, 32'hFFFFFFFF);
    test_ops("remu_zero", 32'h7, 32'd9, 32'd0, 32'd9);
    test_ops("div_ovf", 32'h4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    test_ops("rem_ovf", 32'h6, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    test_ops("divu_zero", 32'h5, 32'd77, 32'd0, 32'hFFFFFFFF);
    test_ops("rem_zero", 32'h6, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0);
    test_ops("undef_op", 32'h8, 32'd5, 32'd5, 32'h0);
    test_mulh();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-004 instruction  input  32  operation word; only instruction[3:0] (op field) is decoded, bits [31:4] ignored.
REQ-005 rs1  input  WIDTH  first operand (multiplicand / dividend).
REQ-006 rs2  input  WIDTH  second operand (multiplier / divisor).
REQ-007 result  output  WIDTH  registered operation result.

Function
REQ-008 The op field SHALL decode as: 0001 MUL, 0010 MULH, 0011 MULHSU, 1001 MULHU, 0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU; all other codes SHALL produce result 0.
REQ-009 MUL SHALL return the low WIDTH bits of rs1*rs2; the low half is identical for signed and unsigned operands.
REQ-010 MULH / MULHSU / MULHU SHALL return the high WIDTH bits of the 2*WIDTH product: signed x signed, signed rs1 x unsigned rs2, and unsigned x unsigned respectively.
REQ-011 DIV / REM SHALL use two's-complement operands, truncate toward zero, and give the remainder the sign of the dividend.
REQ-012 DIVU / REMU SHALL treat both operands as unsigned.
REQ-013 Divide by zero: DIV and DIVU SHALL return all ones; REM and REMU SHALL return rs1.
REQ-014 Signed overflow (rs1 = most negative value, rs2 = -1): DIV SHALL return rs1; REM SHALL return 0.
REQ-015 The operation SHALL be computed combinationally from the current instruction, rs1 and rs2 and captured into result on every posedge clk with reset high; latency is exactly 1 cycle, throughput 1 operation per cycle.
REQ-016 The block SHALL have no handshake and no busy state; result SHALL hold its value only until the next posedge.
REQ-017 An input change between edges SHALL affect only the next captured value, with no glitch on result.

Reset
REQ-018 On a posedge with reset = 0, result SHALL be loaded with 0, overriding any operation.
REQ-019 The first posedge after reset returns high SHALL capture the operation then presented; no warm-up cycles.
REQ-020 Asserting reset mid-stream SHALL discard the in-flight value; no asynchronous path from reset to result.

Configuration
REQ-021 Macro ALU_MULH_EN: when defined, MULH, MULHSU and MULHU SHALL be implemented per REQ-010.
REQ-022 When ALU_MULH_EN is undefined, those three codes SHALL be treated as undefined (result 0) and the high-product logic SHALL be omitted; MUL, DIV, DIVU, REM and REMU are always present.

Verification
REQ-023 Reset held low for 2 edges with any operands -> result = 0; with instruction = 0x...0001, rs1 = 6, rs2 = 7 and reset released -> result = 42 one edge later.
REQ-024 DIV with rs1 = 10, rs2 = 2 -> 5; DIVU with rs1 = 10, rs2 = 2 -> 5; REM with rs1 = 10, rs2 = 3 -> 1; each check one cycle after the inputs are applied.
REQ-025 Signed cases: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF.
REQ-026 Corners: DIV x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-027 High products with ALU_MULH_EN defined: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH -1 x -1 -> 0; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF. With the macro undefined, all three -> 0.
REQ-028 Back-to-back: new op every cycle (MUL, DIV, undefined code 0x0) -> results 42, 5, 0 on three consecutive edges; reset asserted on the middle edge -> 0 on that edge.
